// File: rtl/key_conditioner_pkg.sv
// Shared types and constants for the push-button conditioner.
// Holds the channel state encoding, default cycle counts and sizing helpers.
package key_conditioner_pkg;

    typedef enum logic [1:0] {
        RELEASED    = 2'd0,
        HELD_DELAY  = 2'd1,
        HELD_REPEAT = 2'd2
    } key_state_e;

    // Per-channel outputs, all active-high and synchronous to clk.
    typedef struct packed {
        logic level;
        logic press;
        logic rel;
        logic strobe;
    } key_evt_t;

    localparam int unsigned CLK_HZ_DEFAULT               = 50_000_000;
    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT      = 500_000;
    localparam int unsigned REPEAT_DELAY_CYCLES_DEFAULT  = 25_000_000;
    localparam int unsigned REPEAT_PERIOD_CYCLES_DEFAULT = 5_000_000;

    function automatic int unsigned ms_to_cycles(input int unsigned clk_hz,
                                                 input int unsigned ms);
        return (clk_hz / 1000) * ms;
    endfunction

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/key_channel.sv
// One key: 2-flop synchronizer, restartable debounce counter and the
// press/auto-repeat FSM. All outputs are registered.
module key_channel
    import key_conditioner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES      = DEBOUNCE_CYCLES_DEFAULT,
    parameter bit          REPEAT_EN            = 1'b1,
    parameter int unsigned REPEAT_DELAY_CYCLES  = REPEAT_DELAY_CYCLES_DEFAULT,
    parameter int unsigned REPEAT_PERIOD_CYCLES = REPEAT_PERIOD_CYCLES_DEFAULT
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     key_raw_n,
    output key_evt_t evt
);

    localparam int unsigned DB_W   = cnt_width(DEBOUNCE_CYCLES);
    localparam int unsigned RP_MAX = (REPEAT_DELAY_CYCLES > REPEAT_PERIOD_CYCLES) ?
                                     REPEAT_DELAY_CYCLES : REPEAT_PERIOD_CYCLES;
    localparam int unsigned RP_W   = cnt_width(RP_MAX);

    localparam logic [DB_W-1:0] DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RP_W-1:0] DELAY_LAST  = RP_W'(REPEAT_DELAY_CYCLES - 1);
    localparam logic [RP_W-1:0] PERIOD_LAST = RP_W'(REPEAT_PERIOD_CYCLES - 1);

    logic [1:0]      sync_q;
    logic            key_s;
    logic            level_q;
    logic [DB_W-1:0] db_cnt_q;
    logic            accept;
    logic            press_evt;
    logic            rel_evt;

    key_state_e      state_q, state_d;
    logic [RP_W-1:0] rcnt_q, rcnt_d;
    logic            strobe_d;
    logic            press_q, rel_q, strobe_q;

    // Reset to "released" so a key held through reset is seen as a new press.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) sync_q <= 2'b11;
        else      sync_q <= {sync_q[0], key_raw_n};
    end

    assign key_s     = ~sync_q[1];
    assign accept    = (key_s != level_q) && (db_cnt_q == DB_LAST);
    assign press_evt = accept &  key_s;
    assign rel_evt   = accept & ~key_s;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            level_q  <= 1'b0;
            db_cnt_q <= '0;
        end else if (key_s == level_q) begin
            db_cnt_q <= '0;
        end else if (accept) begin
            level_q  <= key_s;
            db_cnt_q <= '0;
        end else begin
            db_cnt_q <= db_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= RELEASED;
            rcnt_q   <= '0;
            press_q  <= 1'b0;
            rel_q    <= 1'b0;
            strobe_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rcnt_q   <= rcnt_d;
            press_q  <= press_evt;
            rel_q    <= rel_evt;
            strobe_q <= strobe_d;
        end
    end

    // Release takes priority over a repeat that falls due on the same cycle.
    always_comb begin
        state_d  = state_q;
        rcnt_d   = rcnt_q;
        strobe_d = 1'b0;
        unique case (state_q)
            RELEASED: begin
                if (press_evt) begin
                    state_d  = HELD_DELAY;
                    rcnt_d   = '0;
                    strobe_d = 1'b1;
                end
            end
            HELD_DELAY: begin
                if (rel_evt) begin
                    state_d = RELEASED;
                    rcnt_d  = '0;
                end else if (REPEAT_EN) begin
                    if (rcnt_q == DELAY_LAST) begin
                        state_d  = HELD_REPEAT;
                        rcnt_d   = '0;
                        strobe_d = 1'b1;
                    end else begin
                        rcnt_d = rcnt_q + 1'b1;
                    end
                end
            end
            HELD_REPEAT: begin
                if (rel_evt) begin
                    state_d = RELEASED;
                    rcnt_d  = '0;
                end else if (rcnt_q == PERIOD_LAST) begin
                    rcnt_d   = '0;
                    strobe_d = 1'b1;
                end else begin
                    rcnt_d = rcnt_q + 1'b1;
                end
            end
            default: begin
                state_d = RELEASED;
                rcnt_d  = '0;
            end
        endcase
    end

    assign evt.level  = level_q;
    assign evt.press  = press_q;
    assign evt.rel    = rel_q;
    assign evt.strobe = strobe_q;

endmodule

// File: rtl/key_conditioner.sv
// Board push-button conditioner: N_KEYS independent channels turning raw
// active-low KEY pins into debounced level, press/release pulses and a repeat strobe.
module key_conditioner
    import key_conditioner_pkg::*;
#(
    parameter int unsigned N_KEYS               = 2,
    parameter int unsigned DEBOUNCE_CYCLES      = DEBOUNCE_CYCLES_DEFAULT,
    parameter bit          REPEAT_EN            = 1'b1,
    parameter int unsigned REPEAT_DELAY_CYCLES  = REPEAT_DELAY_CYCLES_DEFAULT,
    parameter int unsigned REPEAT_PERIOD_CYCLES = REPEAT_PERIOD_CYCLES_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_KEYS-1:0] key_raw_n,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic [N_KEYS-1:0] key_strobe
);

    key_evt_t [N_KEYS-1:0] evt;

    generate
        for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
            key_channel #(
                .DEBOUNCE_CYCLES      (DEBOUNCE_CYCLES),
                .REPEAT_EN            (REPEAT_EN),
                .REPEAT_DELAY_CYCLES  (REPEAT_DELAY_CYCLES),
                .REPEAT_PERIOD_CYCLES (REPEAT_PERIOD_CYCLES)
            ) u_ch (
                .clk       (clk),
                .rst       (rst),
                .key_raw_n (key_raw_n[i]),
                .evt       (evt[i])
            );

            assign key_level[i]   = evt[i].level;
            assign key_press[i]   = evt[i].press;
            assign key_release[i] = evt[i].rel;
            assign key_strobe[i]  = evt[i].strobe;
        end
    endgenerate

endmodule
